// File: rtl/spi_alu_slave_if.sv
// SPI pin bundle plus ALU result/status outputs of spi_alu_slave.
// The master modport is the board side (SPI master pins and result consumer).
`timescale 1ns/1ps
interface spi_alu_slave_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              ss_n;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] result;
  logic              ovf;
  logic              done;
  logic              frame_err;

  modport slave (
    input  sclk, ss_n, mosi,
    output miso, result, ovf, done, frame_err
  );

  modport master (
    output sclk, ss_n, mosi,
    input  miso, result, ovf, done, frame_err
  );
endinterface

// File: rtl/spi_alu_slave.sv
// SPI mode-0 slave: receives {reserved, opcode[2:0], data} frames and runs a saturating signed ALU.
// Results land 2 clk after the last sampled bit; the previous result is shifted out on miso.
`timescale 1ns/1ps
module spi_alu_slave #(
  parameter int DATA_W   = 8,
  parameter int SYNC_STG = 2
) (
  input  logic            clk,
  input  logic            n_rst,
  spi_alu_slave_if.slave  bus
);

  localparam int FRAME_W = DATA_W + 4;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_AND    = 3'b010;
  localparam logic [2:0] OP_OR     = 3'b011;
  localparam logic [2:0] OP_LOAD_A = 3'b100;
  localparam logic [2:0] OP_NOP    = 3'b101;
  localparam logic [2:0] OP_LOAD_B = 3'b110;
  localparam logic [2:0] OP_CLEAR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EXEC  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  // Synchronisers; ss_n idles high so its chain resets to 1 to avoid a false select
  logic [SYNC_STG-1:0] r_sclk_sync;
  logic [SYNC_STG-1:0] r_ss_sync;
  logic [SYNC_STG-1:0] r_mosi_sync;
  logic                r_sclk_d;
  logic                r_ss_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sclk_sync <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STG-2:0], bus.sclk};
      r_ss_sync   <= {r_ss_sync[SYNC_STG-2:0], bus.ss_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STG-2:0], bus.mosi};
      r_sclk_d    <= r_sclk_sync[SYNC_STG-1];
      r_ss_d      <= r_ss_sync[SYNC_STG-1];
    end
  end

  logic w_sclk;
  logic w_ss;
  logic w_mosi;
  logic w_rise;
  logic w_fall;
  logic w_ss_fall;

  assign w_sclk    = r_sclk_sync[SYNC_STG-1];
  assign w_ss      = r_ss_sync[SYNC_STG-1];
  assign w_mosi    = r_mosi_sync[SYNC_STG-1];
  assign w_rise    = w_sclk & ~r_sclk_d;
  assign w_fall    = ~w_sclk & r_sclk_d;
  assign w_ss_fall = ~w_ss & r_ss_d;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [FRAME_W-1:0]  r_frame;
  logic [DATA_W-1:0]   r_shift_out;
  logic                r_miso;
  logic [DATA_W-1:0]   r_opa;
  logic [DATA_W-1:0]   r_opb;
  logic [DATA_W-1:0]   r_result;
  logic                r_ovf;
  logic                r_done;
  logic                r_frame_err;

  // First received bit sits at the MSB of the frame register
  logic              w_rsv;
  logic [2:0]        w_op;
  logic [DATA_W-1:0] w_data;

  assign w_rsv  = r_frame[FRAME_W-1];
  assign w_op   = r_frame[FRAME_W-2 -: 3];
  assign w_data = r_frame[DATA_W-1:0];

  // Returns {clamped, value}; overflow shows as disagreement of the two top bits
  function automatic logic [DATA_W:0] sat(input logic [DATA_W:0] v);
    if (v[DATA_W] != v[DATA_W-1])
      return {1'b1, v[DATA_W], {(DATA_W-1){~v[DATA_W]}}};
    else
      return {1'b0, v[DATA_W-1:0]};
  endfunction

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;
  logic [DATA_W:0] w_sat_add;
  logic [DATA_W:0] w_sat_sub;
  logic            w_last_rise;

  assign w_sum       = {r_opa[DATA_W-1], r_opa} + {r_opb[DATA_W-1], r_opb};
  assign w_diff      = {r_opa[DATA_W-1], r_opa} - {r_opb[DATA_W-1], r_opb};
  assign w_sat_add   = sat(w_sum);
  assign w_sat_sub   = sat(w_diff);
  assign w_last_rise = w_rise && (r_cnt == CNT_W'(FRAME_W - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_frame     <= '0;
      r_shift_out <= '0;
      r_miso      <= 1'b0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_result    <= '0;
      r_ovf       <= 1'b0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ss_fall) begin
            r_shift_out <= r_result;
            r_miso      <= r_result[DATA_W-1];
            r_cnt       <= '0;
            r_state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (r_cnt == CNT_W'(FRAME_W)) begin
            r_state <= EXEC;
          end else if (w_ss && !w_last_rise) begin
            // Deselect before the last bit: drop the frame, keep operands and result
            r_frame_err <= 1'b1;
            r_miso      <= 1'b0;
            r_state     <= IDLE;
          end else begin
            if (w_rise) begin
              r_frame <= {r_frame[FRAME_W-2:0], w_mosi};
              r_cnt   <= r_cnt + 1'b1;
            end
            // Zeros fill in behind, so miso falls to 0 once DATA_W bits are out
            if (w_fall) begin
              r_shift_out <= {r_shift_out[DATA_W-2:0], 1'b0};
              r_miso      <= r_shift_out[DATA_W-2];
            end
          end
        end

        EXEC: begin
          r_miso  <= 1'b0;
          r_state <= WAIT;
          if (w_rsv) begin
            r_frame_err <= 1'b1;
          end else begin
            r_done <= 1'b1;
            case (w_op)
              OP_ADD: begin
                r_result <= w_sat_add[DATA_W-1:0];
                r_ovf    <= w_sat_add[DATA_W];
              end
              OP_SUB: begin
                r_result <= w_sat_sub[DATA_W-1:0];
                r_ovf    <= w_sat_sub[DATA_W];
              end
              OP_AND: begin
                r_result <= r_opa & r_opb;
                r_ovf    <= 1'b0;
              end
              OP_OR: begin
                r_result <= r_opa | r_opb;
                r_ovf    <= 1'b0;
              end
              OP_LOAD_A: r_opa <= w_data;
              OP_LOAD_B: r_opb <= w_data;
              OP_CLEAR: begin
                r_opa    <= '0;
                r_opb    <= '0;
                r_result <= '0;
                r_ovf    <= 1'b0;
              end
              default: ; // NOP/READ: frame only clocks out the old result
            endcase
          end
        end

        WAIT: begin
          // Level test: a deselect coincident with the last bit was already seen
          r_miso <= 1'b0;
          if (w_ss)
            r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.miso      = r_miso;
  assign bus.result    = r_result;
  assign bus.ovf       = r_ovf;
  assign bus.done      = r_done;
  assign bus.frame_err = r_frame_err;

endmodule
